// File: rtl/avalon_mem_burst_if.sv
// avalon_mem_burst_if: Avalon-MM burst bus between the burst master and the interconnect
interface avalon_mem_burst_if #(
  parameter int DW = 32,
  parameter int BURST_MAX = 4
);
  localparam int BCW = $clog2(BURST_MAX) + 1;
  localparam int BEW = DW / 8;
  logic [31:0]    address;
  logic [DW-1:0]  writedata;
  logic [BEW-1:0] byteenable;
  logic [BCW-1:0] burstcount;
  logic           write;
  logic           read;
  logic           waitrequest;
  logic           readdatavalid;
  logic [DW-1:0]  readdata;
  modport master (
    output address, writedata, byteenable, burstcount, write, read,
    input  waitrequest, readdatavalid, readdata
  );
  modport slave (
    input  address, writedata, byteenable, burstcount, write, read,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/avalon_mem_burst.sv
// avalon_mem_burst: round-robin Avalon-MM burst master for one write and one read requester
module avalon_mem_burst #(
  parameter int DW = 32,
  parameter int BURST_MAX = 4,
  localparam int BCW = $clog2(BURST_MAX) + 1,
  localparam int BEW = DW / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_do,
  output logic                    wr_done,
  input  logic [31:0]             wr_address,
  input  logic [BCW-1:0]          wr_burstcount,
  input  logic [BEW-1:0]          wr_be_first,
  input  logic [BEW-1:0]          wr_be_last,
  input  logic [DW*BURST_MAX-1:0] wr_line,
  input  logic                    rd_do,
  output logic                    rd_done,
  input  logic [31:0]             rd_address,
  input  logic [BCW-1:0]          rd_burstcount,
  input  logic [BEW-1:0]          rd_be,
  output logic [DW*BURST_MAX-1:0] rd_line,
  output logic [DW-1:0]           rd_partial,
  output logic                    rd_partial_valid,
  avalon_mem_burst_if.master      avm
);
  localparam logic [31:0] ALIGN = ~32'(BEW - 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t                  state;
  logic                    last_wr;
  logic [BCW-1:0]          cnt;
  logic [BCW-1:0]          idx;
  logic [BEW-1:0]          be_last;
  logic [DW*BURST_MAX-1:0] buffer;
  logic                    rd_cand;
  logic                    wr_grant;
  logic                    rd_grant;
  // Arbitration: a read is masked while its done pulse is out, ties go opposite the last grant
  always_comb begin
    rd_cand  = rd_do && !rd_done;
    wr_grant = state == IDLE && wr_do && (!rd_cand || !last_wr);
    rd_grant = state == IDLE && rd_cand && !wr_grant;
    wr_done  = wr_grant;
  end
  // Burst sequencer: issues write beats from the captured line and collects read beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_wr          <= 1'b0;
      cnt              <= '0;
      idx              <= '0;
      be_last          <= '0;
      buffer           <= '0;
      rd_done          <= 1'b0;
      rd_line          <= '0;
      rd_partial       <= '0;
      rd_partial_valid <= 1'b0;
      avm.address      <= '0;
      avm.writedata    <= '0;
      avm.byteenable   <= '0;
      avm.burstcount   <= '0;
      avm.write        <= 1'b0;
      avm.read         <= 1'b0;
    end else begin
      rd_done          <= 1'b0;
      rd_partial_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_grant) begin
            last_wr <= 1'b1;
            if (wr_burstcount != '0) begin
              avm.address    <= wr_address & ALIGN;
              avm.burstcount <= wr_burstcount;
              avm.writedata  <= wr_line[DW-1:0];
              avm.byteenable <= wr_be_first;
              avm.write      <= 1'b1;
              be_last        <= wr_be_last;
              buffer         <= wr_line >> DW;
              cnt            <= wr_burstcount - 1'b1;
              state          <= WRITE;
            end
          end else if (rd_grant) begin
            last_wr <= 1'b0;
            if (rd_burstcount == '0) begin
              rd_done <= 1'b1;
            end else begin
              avm.address    <= rd_address & ALIGN;
              avm.burstcount <= rd_burstcount;
              avm.byteenable <= rd_burstcount == BCW'(1) ? rd_be : '1;
              avm.read       <= 1'b1;
              idx            <= '0;
              state          <= READ;
            end
          end
        end
        WRITE: begin
          if (!avm.waitrequest) begin
            if (cnt == '0) begin
              avm.write <= 1'b0;
              state     <= IDLE;
            end else begin
              avm.writedata  <= buffer[DW-1:0];
              avm.byteenable <= cnt == BCW'(1) ? be_last : '1;
              buffer         <= buffer >> DW;
              cnt            <= cnt - 1'b1;
            end
          end
        end
        READ: begin
          if (avm.read && !avm.waitrequest) avm.read <= 1'b0;
          if (avm.readdatavalid) begin
            for (int k = 0; k < BURST_MAX; k++)
              if (idx == BCW'(k)) rd_line[k*DW +: DW] <= avm.readdata;
            rd_partial       <= avm.readdata;
            rd_partial_valid <= 1'b1;
            idx              <= idx + 1'b1;
            if (idx == avm.burstcount - 1'b1) begin
              rd_done <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Requesters must never ask for more beats than a line holds
  assert property (@(posedge clk) disable iff (!rst_n) wr_do |-> wr_burstcount <= BCW'(BURST_MAX));
  assert property (@(posedge clk) disable iff (!rst_n) rd_do |-> rd_burstcount <= BCW'(BURST_MAX));
endmodule

// File: tb/tb_avalon_mem_burst.sv
// tb_avalon_mem_burst: scoreboard bench for the burst master at 32x4 (a_) and 64x8 (b_)
module tb_avalon_mem_burst;
  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wbeat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  logic         a_wr_do = 0, a_rd_do = 0, a_wr_done, a_rd_done, a_rd_pv;
  logic [31:0]  a_wr_address = 0, a_rd_address = 0, a_rd_partial;
  logic [2:0]   a_wr_bc = 0, a_rd_bc = 0;
  logic [3:0]   a_bef = 0, a_bel = 0, a_rd_be = 0;
  logic [127:0] a_wr_line = 0, a_rd_line;
  logic         b_wr_do = 0, b_rd_do = 0, b_wr_done, b_rd_done, b_rd_pv;
  logic [31:0]  b_wr_address = 0, b_rd_address = 0;
  logic [63:0]  b_rd_partial;
  logic [3:0]   b_wr_bc = 0, b_rd_bc = 0;
  logic [7:0]   b_bef = 0, b_bel = 0, b_rd_be = 0;
  logic [511:0] b_wr_line = 0, b_rd_line, saved_line;
  wbeat_t      qa_w[$], qb_w[$];
  logic [63:0] qa_r[$], qb_r[$];
  logic        order[$];
  int a_wcyc = 0, a_rcyc = 0, a_pv_cnt = 0, a_wd_cnt = 0;
  int b_wcyc = 0, b_rcyc = 0, b_pv_cnt = 0, b_rd_cnt = 0;
  logic a_prev_read = 0;
  int n;

  avalon_mem_burst_if #(.DW(32), .BURST_MAX(4)) a_bus ();
  avalon_mem_burst_if #(.DW(64), .BURST_MAX(8)) b_bus ();

  avalon_mem_burst #(.DW(32), .BURST_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .wr_do(a_wr_do), .wr_done(a_wr_done), .wr_address(a_wr_address), .wr_burstcount(a_wr_bc),
    .wr_be_first(a_bef), .wr_be_last(a_bel), .wr_line(a_wr_line),
    .rd_do(a_rd_do), .rd_done(a_rd_done), .rd_address(a_rd_address), .rd_burstcount(a_rd_bc),
    .rd_be(a_rd_be), .rd_line(a_rd_line), .rd_partial(a_rd_partial), .rd_partial_valid(a_rd_pv),
    .avm(a_bus)
  );

  avalon_mem_burst #(.DW(64), .BURST_MAX(8)) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr_do(b_wr_do), .wr_done(b_wr_done), .wr_address(b_wr_address), .wr_burstcount(b_wr_bc),
    .wr_be_first(b_bef), .wr_be_last(b_bel), .wr_line(b_wr_line),
    .rd_do(b_rd_do), .rd_done(b_rd_done), .rd_address(b_rd_address), .rd_burstcount(b_rd_bc),
    .rd_be(b_rd_be), .rd_line(b_rd_line), .rd_partial(b_rd_partial), .rd_partial_valid(b_rd_pv),
    .avm(b_bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bdat(input int k);
    return {32'hBEEF0000 + 32'(k), ~32'(k * 7)};
  endfunction

  // A-side monitor: bus write beats and read beats against the scoreboard
  always @(negedge clk) begin
    if (a_bus.write) begin
      a_wcyc++;
      if (qa_w.size() == 0) check("a_wr_extra", a_bus.write, 0);
      else begin
        check("a_wr_addr", a_bus.address, qa_w[0].addr);
        check("a_wr_data", a_bus.writedata, qa_w[0].data);
        check("a_wr_be", a_bus.byteenable, qa_w[0].be);
        if (!a_bus.waitrequest) qa_w.delete(0);
      end
    end
    if (a_rd_pv) begin
      a_pv_cnt++;
      if (qa_r.size() == 0) check("a_pv_extra", a_rd_pv, 0);
      else check("a_rd_partial", a_rd_partial, qa_r.pop_front());
    end
    if (a_bus.read) a_rcyc++;
    if (a_wr_done) begin
      a_wd_cnt++;
      order.push_back(1'b1);
    end
    if (a_bus.read && !a_prev_read) order.push_back(1'b0);
    a_prev_read = a_bus.read;
  end

  // B-side monitor: same scoreboard checks for the 64x8 instance
  always @(negedge clk) begin
    if (b_bus.write) begin
      b_wcyc++;
      if (qb_w.size() == 0) check("b_wr_extra", b_bus.write, 0);
      else begin
        check("b_wr_addr", b_bus.address, qb_w[0].addr);
        check("b_wr_data", b_bus.writedata, qb_w[0].data);
        if (!b_bus.waitrequest) qb_w.delete(0);
      end
    end
    if (b_rd_pv) begin
      b_pv_cnt++;
      if (qb_r.size() == 0) check("b_pv_extra", b_rd_pv, 0);
      else check("b_rd_partial", b_rd_partial, qb_r.pop_front());
    end
    if (b_bus.read) b_rcyc++;
    if (b_rd_done) b_rd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a_bus.waitrequest = 0; a_bus.readdatavalid = 0; a_bus.readdata = 0;
    b_bus.waitrequest = 0; b_bus.readdatavalid = 0; b_bus.readdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_write", a_bus.write, 0);
    check("rst_a_read", a_bus.read, 0);
    check("rst_a_addr", a_bus.address, 0);
    check("rst_a_done", {a_wr_done, a_rd_done, a_rd_pv}, 0);
    check("rst_a_line", a_rd_line[63:0], 0);
    check("rst_b_bus", {b_bus.write, b_bus.read, b_bus.burstcount, b_bus.byteenable}, 0);
    check("rst_b_partial", b_rd_partial, 0);
    rst_n = 1;

    // 4-beat write, unaligned address, two-cycle stall on beat 1
    @(posedge clk); #1;
    a_wr_address = 32'h1003; a_wr_bc = 4; a_bef = 4'hE; a_bel = 4'h7;
    a_wr_line = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    qa_w.push_back('{32'h1000, 64'h11111111, 8'hE});
    qa_w.push_back('{32'h1000, 64'h22222222, 8'hF});
    qa_w.push_back('{32'h1000, 64'h33333333, 8'hF});
    qa_w.push_back('{32'h1000, 64'h44444444, 8'h7});
    a_wcyc = 0; a_wd_cnt = 0;
    a_wr_do = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_wr_done && n < 20);
    check("t1_wr_done", a_wr_done, 1);
    @(posedge clk); #1 a_wr_do = 0;
    @(posedge clk); #1 a_bus.waitrequest = 1;
    repeat (2) @(posedge clk);
    #1 a_bus.waitrequest = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (a_bus.write && n < 20);
    #1;
    check("t1_write_low", a_bus.write, 0);
    check("t1_wq_empty", qa_w.size(), 0);
    check("t1_write_cycles", a_wcyc, 6);
    check("t1_wr_done_cnt", a_wd_cnt, 1);

    // 1-beat read with byte enables, data returned three cycles later
    @(posedge clk); #1;
    a_rd_address = 32'h2002; a_rd_bc = 1; a_rd_be = 4'hC;
    qa_r.push_back(64'hDEADBEEF);
    a_rcyc = 0; a_pv_cnt = 0;
    a_rd_do = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_bus.read && n < 20);
    check("t2_read", a_bus.read, 1);
    check("t2_addr", a_bus.address, 32'h2000);
    check("t2_bc", a_bus.burstcount, 1);
    check("t2_be", a_bus.byteenable, 4'hC);
    repeat (3) @(posedge clk);
    #1 a_bus.readdatavalid = 1; a_bus.readdata = 32'hDEADBEEF;
    @(posedge clk); #1 a_bus.readdatavalid = 0;
    @(negedge clk);
    check("t2_rd_done", a_rd_done, 1);
    check("t2_rd_pv", a_rd_pv, 1);
    check("t2_line", a_rd_line[31:0], 32'hDEADBEEF);
    @(posedge clk); #1 a_rd_do = 0;
    @(negedge clk); #1;
    check("t2_read_cycles", a_rcyc, 1);
    check("t2_pv_cnt", a_pv_cnt, 1);
    check("t2_rq_empty", qa_r.size(), 0);

    // Simultaneous requests twice: write, then read, then the re-requested write
    @(posedge clk); #1;
    order.delete();
    a_wr_address = 32'h3000; a_wr_bc = 1; a_bef = 4'hF; a_wr_line = 128'hA5A5A5A5;
    qa_w.push_back('{32'h3000, 64'hA5A5A5A5, 8'hF});
    a_rd_address = 32'h4000; a_rd_bc = 1; a_rd_be = 4'hF;
    qa_r.push_back(64'h12345678);
    a_wr_do = 1; a_rd_do = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_wr_done && n < 20);
    check("t3_first_wr", a_wr_done, 1);
    @(posedge clk); #1;
    a_wr_address = 32'h3004; a_wr_line = 128'h5A5A5A5A;
    qa_w.push_back('{32'h3004, 64'h5A5A5A5A, 8'hF});
    n = 0;
    do begin @(negedge clk); n++; end while (!a_bus.read && n < 20);
    check("t3_read", a_bus.read, 1);
    @(posedge clk); #1 a_bus.readdatavalid = 1; a_bus.readdata = 32'h12345678;
    @(posedge clk); #1 a_bus.readdatavalid = 0;
    @(negedge clk);
    check("t3_rd_done", a_rd_done, 1);
    check("t3_wr_in_rd_done", a_wr_done, 1);
    @(posedge clk); #1 a_wr_do = 0; a_rd_do = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (a_bus.write && n < 20);
    #1;
    check("t3_order_len", order.size(), 3);
    if (order.size() == 3) check("t3_order", {order[0], order[1], order[2]}, 3'b101);
    check("t3_wq_empty", qa_w.size(), 0);
    check("t3_rq_empty", qa_r.size(), 0);

    // 8-beat read on the 64-bit instance with gaps between beats
    @(posedge clk); #1;
    b_rd_address = 32'h800C; b_rd_bc = 8; b_rd_be = 8'h0F;
    for (int k = 0; k < 8; k++) qb_r.push_back(bdat(k));
    b_rcyc = 0; b_pv_cnt = 0;
    b_rd_do = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_bus.read && n < 20);
    check("t4_read", b_bus.read, 1);
    check("t4_addr", b_bus.address, 32'h8008);
    check("t4_bc", b_bus.burstcount, 8);
    check("t4_be", b_bus.byteenable, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 b_bus.readdatavalid = 1; b_bus.readdata = bdat(k);
      @(posedge clk); #1 b_bus.readdatavalid = 0;
      if (k < 7) repeat (k % 3) @(posedge clk);
    end
    @(negedge clk);
    check("t4_rd_done", b_rd_done, 1);
    check("t4_rd_pv", b_rd_pv, 1);
    @(posedge clk); #1 b_rd_do = 0;
    @(negedge clk); #1;
    check("t4_pv_cnt", b_pv_cnt, 8);
    check("t4_read_cycles", b_rcyc, 1);
    check("t4_rq_empty", qb_r.size(), 0);
    for (int k = 0; k < 8; k++) check("t4_slot", b_rd_line[k*64 +: 64], bdat(k));

    // Zero-length write and read: done pulses only, no bus activity
    @(posedge clk); #1;
    b_wcyc = 0; b_rcyc = 0; b_pv_cnt = 0; b_rd_cnt = 0;
    b_wr_address = 32'h5000; b_wr_bc = 0; b_wr_do = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_wr_done && n < 20);
    check("t6_wr_done", b_wr_done, 1);
    @(posedge clk); #1;
    b_wr_do = 0;
    b_rd_bc = 0; b_rd_do = 1;
    saved_line = b_rd_line;
    @(negedge clk);
    check("t6_rd_done_early", b_rd_done, 0);
    @(negedge clk);
    check("t6_rd_done", b_rd_done, 1);
    @(posedge clk); #1 b_rd_do = 0;
    repeat (3) @(negedge clk);
    #1;
    check("t6_rd_done_cnt", b_rd_cnt, 1);
    check("t6_no_bus", {b_wcyc[15:0], b_rcyc[15:0]}, 0);
    check("t6_no_pv", b_pv_cnt, 0);
    check("t6_line_kept", b_rd_line == saved_line, 1);

    // Reset during beat 2 of a 4-beat read; late beats after release are ignored
    @(posedge clk); #1;
    b_rd_address = 32'h9000; b_rd_bc = 4; b_rd_do = 1;
    b_pv_cnt = 0; b_rd_cnt = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_bus.read && n < 20);
    check("t5_read", b_bus.read, 1);
    qb_r.push_back(bdat(10));
    qb_r.push_back(bdat(11));
    @(posedge clk); #1 b_bus.readdatavalid = 1; b_bus.readdata = bdat(10);
    @(posedge clk); #1 b_bus.readdata = bdat(11);
    @(posedge clk); #1 b_bus.readdatavalid = 0;
    @(posedge clk); #1;
    b_bus.readdatavalid = 1; b_bus.readdata = bdat(12);
    rst_n = 0; b_rd_do = 0;
    #1;
    check("t5_rst_read", b_bus.read, 0);
    check("t5_rst_bus", {b_bus.address, b_bus.burstcount, b_bus.byteenable}, 0);
    check("t5_rst_pv", b_rd_pv, 0);
    check("t5_rst_partial", b_rd_partial, 0);
    check("t5_rst_line", b_rd_line[127:64], 0);
    check("t5_pv_before", b_pv_cnt, 2);
    @(posedge clk); #1 rst_n = 1; b_bus.readdata = bdat(13);
    @(posedge clk); #1 b_bus.readdatavalid = 0;
    repeat (3) @(negedge clk);
    #1;
    check("t5_pv_after", b_pv_cnt, 2);
    check("t5_no_done", b_rd_cnt, 0);
    check("t5_rq_empty", qb_r.size(), 0);
    check("t5_line_zero", b_rd_line[63:0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
